// File: rtl/segment_descriptor_loader_if.sv
// Memory port of the segment descriptor loader: one dword request at a time
// with a ready handshake and a separate read-data valid strobe.
interface segment_descriptor_loader_if;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;

  modport master (
    output mem_request,
    output mem_write,
    output mem_address,
    output mem_write_data,
    input  mem_ready,
    input  mem_read_valid,
    input  mem_read_data
  );

  modport slave (
    input  mem_request,
    input  mem_write,
    input  mem_address,
    input  mem_write_data,
    output mem_ready,
    output mem_read_valid,
    output mem_read_data
  );
endinterface

// File: rtl/segment_descriptor_loader.sv
// Fetches and validates an 8-byte GDT/LDT descriptor for a selector, sets its
// accessed bit in memory when needed, and commits it to a segment register.
module segment_descriptor_loader #(
  parameter bit REQUIRE_CODE = 1'b1,
  parameter bit NULL_ALLOWED = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [15:0]                   load_selector,
  input  logic [31:0]                   GDTR_base,
  input  logic [15:0]                   GDTR_limit,
  input  logic [31:0]                   LDTR_base,
  input  logic [31:0]                   LDTR_limit,
  segment_descriptor_loader_if.master   mem,
  output logic                          selector_write_enable,
  output logic [15:0]                   selector_write_data,
  output logic                          descriptor_write_enable,
  output logic [63:0]                   descriptor_write_data,
  output logic                          done,
  output logic                          fault,
  output logic [1:0]                    fault_type,
  output logic [15:0]                   error_code
);

  typedef enum logic [3:0] {
    IDLE, CHECK, RD_LO, WAIT_LO, RD_HI, WAIT_HI, VALIDATE, WRITEBACK, COMMIT, FAULT
  } state_t;

  localparam logic [1:0] FT_NONE = 2'd0;
  localparam logic [1:0] FT_GP   = 2'd1;
  localparam logic [1:0] FT_NP   = 2'd2;

  state_t      state;
  logic [15:0] sel_q;
  logic [31:0] desc_lo;
  logic [31:0] desc_hi;

  logic [31:0] tbl_base;
  logic [31:0] tbl_limit;
  logic [31:0] entry_last;
  logic [31:0] addr_lo;
  logic [15:0] sel_code;
  logic        is_null;
  logic        bad_type;

  // Table lookup uses the latched selector; TI picks LDT over GDT.
  always_comb begin
    tbl_base   = sel_q[2] ? LDTR_base  : GDTR_base;
    tbl_limit  = sel_q[2] ? LDTR_limit : {16'h0000, GDTR_limit};
    entry_last = {16'h0000, sel_q[15:3], 3'b111};
    addr_lo    = tbl_base + {16'h0000, sel_q[15:3], 3'b000};
    sel_code   = {sel_q[15:2], 2'b00};
    is_null    = (sel_q[15:2] == 14'd0);
    bad_type   = !desc_hi[12] || (desc_hi[11] != REQUIRE_CODE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      load_ready              <= 1'b1;
      sel_q                   <= '0;
      desc_lo                 <= '0;
      desc_hi                 <= '0;
      mem.mem_request         <= 1'b0;
      mem.mem_write           <= 1'b0;
      mem.mem_address         <= '0;
      mem.mem_write_data      <= '0;
      selector_write_enable   <= 1'b0;
      selector_write_data     <= '0;
      descriptor_write_enable <= 1'b0;
      descriptor_write_data   <= '0;
      done                    <= 1'b0;
      fault                   <= 1'b0;
      fault_type              <= FT_NONE;
      error_code              <= '0;
    end else begin
      done                    <= 1'b0;
      selector_write_enable   <= 1'b0;
      descriptor_write_enable <= 1'b0;

      case (state)
        IDLE: begin
          if (load_valid) begin
            sel_q      <= load_selector;
            load_ready <= 1'b0;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (is_null) begin
            if (NULL_ALLOWED) begin
              done                    <= 1'b1;
              selector_write_enable   <= 1'b1;
              descriptor_write_enable <= 1'b1;
              selector_write_data     <= sel_q;
              descriptor_write_data   <= '0;
              fault                   <= 1'b0;
              fault_type              <= FT_NONE;
              error_code              <= '0;
              state                   <= COMMIT;
            end else begin
              done       <= 1'b1;
              fault      <= 1'b1;
              fault_type <= FT_GP;
              error_code <= '0;
              state      <= FAULT;
            end
          end else if (entry_last > tbl_limit) begin
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_type <= FT_GP;
            error_code <= sel_code;
            state      <= FAULT;
          end else begin
            mem.mem_request <= 1'b1;
            mem.mem_write   <= 1'b0;
            mem.mem_address <= addr_lo;
            state           <= RD_LO;
          end
        end

        RD_LO: begin
          if (mem.mem_ready) begin
            mem.mem_request <= 1'b0;
            state           <= WAIT_LO;
          end
        end

        // High dword sits 4 bytes above the low one, modulo 2^32.
        WAIT_LO: begin
          if (mem.mem_read_valid) begin
            desc_lo         <= mem.mem_read_data;
            mem.mem_request <= 1'b1;
            mem.mem_address <= mem.mem_address + 32'd4;
            state           <= RD_HI;
          end
        end

        RD_HI: begin
          if (mem.mem_ready) begin
            mem.mem_request <= 1'b0;
            state           <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          if (mem.mem_read_valid) begin
            desc_hi <= mem.mem_read_data;
            state   <= VALIDATE;
          end
        end

        VALIDATE: begin
          if (bad_type) begin
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_type <= FT_GP;
            error_code <= sel_code;
            state      <= FAULT;
          end else if (!desc_hi[15]) begin
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_type <= FT_NP;
            error_code <= sel_code;
            state      <= FAULT;
          end else if (!desc_hi[8]) begin
            // mem_address still holds the high dword address from RD_HI.
            mem.mem_request    <= 1'b1;
            mem.mem_write      <= 1'b1;
            mem.mem_write_data <= desc_hi | 32'h0000_0100;
            state              <= WRITEBACK;
          end else begin
            done                    <= 1'b1;
            selector_write_enable   <= 1'b1;
            descriptor_write_enable <= 1'b1;
            selector_write_data     <= sel_q;
            descriptor_write_data   <= {desc_hi, desc_lo};
            fault                   <= 1'b0;
            fault_type              <= FT_NONE;
            error_code              <= '0;
            state                   <= COMMIT;
          end
        end

        WRITEBACK: begin
          if (mem.mem_ready) begin
            mem.mem_request         <= 1'b0;
            mem.mem_write           <= 1'b0;
            done                    <= 1'b1;
            selector_write_enable   <= 1'b1;
            descriptor_write_enable <= 1'b1;
            selector_write_data     <= sel_q;
            descriptor_write_data   <= {desc_hi | 32'h0000_0100, desc_lo};
            fault                   <= 1'b0;
            fault_type              <= FT_NONE;
            error_code              <= '0;
            state                   <= COMMIT;
          end
        end

        COMMIT, FAULT: begin
          load_ready <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          load_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Directed bench for segment_descriptor_loader with a one-outstanding dword
// memory model; a second instance covers the null-allowed configuration.
module tb_segment_descriptor_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_valid, load_valid_n;
  logic [15:0] load_selector;
  logic [31:0] gdtr_base, ldtr_base, ldtr_limit;
  logic [15:0] gdtr_limit;

  logic        load_ready, swe, dwe, done, fault;
  logic [15:0] swd, error_code;
  logic [63:0] dwd;
  logic [1:0]  fault_type;

  logic        load_ready_n, swe_n, dwe_n, done_n, fault_n;
  logic [15:0] swd_n, error_code_n;
  logic [63:0] dwd_n;
  logic [1:0]  fault_type_n;

  segment_descriptor_loader_if mem_if ();
  segment_descriptor_loader_if mem_n_if ();

  segment_descriptor_loader #(.REQUIRE_CODE(1'b1), .NULL_ALLOWED(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_selector(load_selector),
    .GDTR_base(gdtr_base), .GDTR_limit(gdtr_limit),
    .LDTR_base(ldtr_base), .LDTR_limit(ldtr_limit),
    .mem(mem_if.master),
    .selector_write_enable(swe), .selector_write_data(swd),
    .descriptor_write_enable(dwe), .descriptor_write_data(dwd),
    .done(done), .fault(fault), .fault_type(fault_type), .error_code(error_code)
  );

  segment_descriptor_loader #(.REQUIRE_CODE(1'b0), .NULL_ALLOWED(1'b1)) dut_n (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid_n), .load_ready(load_ready_n), .load_selector(load_selector),
    .GDTR_base(gdtr_base), .GDTR_limit(gdtr_limit),
    .LDTR_base(ldtr_base), .LDTR_limit(ldtr_limit),
    .mem(mem_n_if.master),
    .selector_write_enable(swe_n), .selector_write_data(swd_n),
    .descriptor_write_enable(dwe_n), .descriptor_write_data(dwd_n),
    .done(done_n), .fault(fault_n), .fault_type(fault_type_n), .error_code(error_code_n)
  );

  always #5 clock = ~clock;

  // Memory model: accepts when mem_ready, returns read data the next cycle.
  logic [31:0] desc_lo_m, desc_hi_m;
  logic        hold_hi;
  logic [31:0] rd_addr_log [0:63];
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(posedge clock) begin
    mem_if.mem_read_valid <= 1'b0;
    if (mem_if.mem_request && mem_if.mem_ready) begin
      if (mem_if.mem_write) begin
        wr_addr_log[wr_cnt[5:0]] <= mem_if.mem_address;
        wr_data_log[wr_cnt[5:0]] <= mem_if.mem_write_data;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_addr_log[rd_cnt[5:0]] <= mem_if.mem_address;
        rd_cnt <= rd_cnt + 1;
        if (!(hold_hi && mem_if.mem_address[2])) begin
          mem_if.mem_read_valid <= 1'b1;
          mem_if.mem_read_data  <= mem_if.mem_address[2] ? desc_hi_m : desc_lo_m;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic got;
  logic        c_fault, c_swe, c_dwe;
  logic [1:0]  c_ftype;
  logic [15:0] c_err, c_swd;
  logic [63:0] c_dwd;
  int r0, w0, cnt;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic start_load(input string tag, input logic [15:0] s);
    @(negedge clock);
    check({tag, "_ready"}, load_ready, 1'b1);
    load_selector = s;
    load_valid    = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    lat = 1;
    got = done;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      got = done;
    end
    c_fault = fault;  c_ftype = fault_type; c_err = error_code;
    c_swe   = swe;    c_dwe   = dwe;        c_swd = swd;  c_dwd = dwd;
    check({tag, "_done"}, got, 1'b1);
    @(negedge clock);
    check({tag, "_pulse"}, {done, swe, dwe}, 3'b000);
  endtask

  task automatic do_load(input string tag, input logic [15:0] s);
    r0 = rd_cnt;
    w0 = wr_cnt;
    start_load(tag, s);
    wait_done(tag);
  endtask

  initial begin
    load_valid = 1'b0; load_valid_n = 1'b0; load_selector = 16'h0000;
    gdtr_base = 32'h0000_1000; gdtr_limit = 16'h00FF;
    ldtr_base = 32'h0000_2000; ldtr_limit = 32'h0000_00FF;
    desc_lo_m = 32'h0000_FFFF; desc_hi_m = 32'h00CF_9B00; hold_hi = 1'b0;
    mem_if.mem_ready = 1'b1;
    mem_n_if.mem_ready = 1'b1; mem_n_if.mem_read_valid = 1'b0; mem_n_if.mem_read_data = 32'h0;

    repeat (2) @(negedge clock);
    check("rst_ready", load_ready, 1'b1);
    check("rst_outs", {mem_if.mem_request, done, fault, swe, dwe}, 5'b0);
    check("rst_data", {dwd, swd, error_code}, 96'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Plain GDT code-segment load, already accessed.
    do_load("gdt", 16'h0008);
    check("gdt_lat", lat, 7);
    check("gdt_fault", {c_fault, c_ftype}, 3'b000);
    check("gdt_we", {c_swe, c_dwe}, 2'b11);
    check("gdt_desc", c_dwd, 64'h00CF9B00_0000FFFF);
    check("gdt_sel", c_swd, 16'h0008);
    check("gdt_nrd", rd_cnt - r0, 2);
    check("gdt_rd0", rd_addr_log[r0[5:0]], 32'h0000_1008);
    check("gdt_rd1", rd_addr_log[6'(r0 + 1)], 32'h0000_100C);
    check("gdt_nwr", wr_cnt - w0, 0);

    // Accessed bit clear: writeback of the high dword.
    desc_hi_m = 32'h00CF_9A00;
    do_load("wb", 16'h0008);
    check("wb_lat", lat, 8);
    check("wb_nwr", wr_cnt - w0, 1);
    check("wb_waddr", wr_addr_log[w0[5:0]], 32'h0000_100C);
    check("wb_wdata", wr_data_log[w0[5:0]], 32'h00CF_9B00);
    check("wb_desc", c_dwd, 64'h00CF9B00_0000FFFF);
    check("wb_fault", c_fault, 1'b0);

    // Limit fault, no memory traffic.
    gdtr_limit = 16'h000F;
    do_load("lim", 16'h0010);
    check("lim_lat", lat, 2);
    check("lim_fault", {c_fault, c_ftype}, 3'b101);
    check("lim_err", c_err, 16'h0010);
    check("lim_nrd", rd_cnt - r0, 0);
    check("lim_we", {c_swe, c_dwe}, 2'b00);

    do_load("rpl", 16'h001B);
    check("rpl_err", c_err, 16'h0018);

    // Last entry exactly at the limit, base wrapping past 2^32.
    gdtr_base = 32'hFFFF_FFF8;
    desc_hi_m = 32'h00CF_9B00;
    do_load("wrap", 16'h0008);
    check("wrap_fault", c_fault, 1'b0);
    check("wrap_rd0", rd_addr_log[r0[5:0]], 32'h0000_0000);
    check("wrap_rd1", rd_addr_log[6'(r0 + 1)], 32'h0000_0004);
    gdtr_base  = 32'h0000_1000;
    gdtr_limit = 16'h00FF;

    // LDT, not present.
    desc_hi_m = 32'h00CF_1B00;
    do_load("np", 16'h000C);
    check("np_fault", {c_fault, c_ftype}, 3'b110);
    check("np_err", c_err, 16'h000C);
    check("np_rd0", rd_addr_log[r0[5:0]], 32'h0000_2008);

    // Data segment when code is required.
    desc_hi_m = 32'h00CF_9300;
    do_load("type", 16'h0008);
    check("type_fault", {c_fault, c_ftype}, 3'b101);
    check("type_err", c_err, 16'h0008);
    check("type_lat", lat, 7);

    do_load("null", 16'h0003);
    check("null_fault", {c_fault, c_ftype}, 3'b101);
    check("null_err", c_err, 16'h0000);
    check("null_nrd", rd_cnt - r0, 0);

    // Null selector on the null-allowed instance.
    @(negedge clock);
    check("nulln_ready", load_ready_n, 1'b1);
    load_selector = 16'h0003;
    load_valid_n  = 1'b1;
    @(negedge clock);
    load_valid_n = 1'b0;
    cnt = 0;
    while (!done_n && cnt < 20) begin @(negedge clock); cnt++; end
    check("nulln_done", done_n, 1'b1);
    check("nulln_fault", {fault_n, fault_type_n}, 3'b000);
    check("nulln_we", {swe_n, dwe_n}, 2'b11);
    check("nulln_sel", swd_n, 16'h0003);
    check("nulln_desc", dwd_n, 64'h0);
    check("nulln_mem", mem_n_if.mem_request, 1'b0);

    // Stall: address held while mem_ready is low.
    desc_hi_m = 32'h00CF_9B00;
    mem_if.mem_ready = 1'b0;
    start_load("stall", 16'h0008);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {mem_if.mem_request, mem_if.mem_write, mem_if.mem_address}, {2'b10, 32'h0000_1008});
      @(negedge clock);
    end
    mem_if.mem_ready = 1'b1;
    wait_done("stall");
    check("stall_desc", c_dwd, 64'h00CF9B00_0000FFFF);
    check("stall_fault", c_fault, 1'b0);

    // Reset while waiting for the high dword.
    hold_hi = 1'b1;
    r0 = rd_cnt;
    start_load("rsthi", 16'h0008);
    cnt = 0;
    while (rd_cnt != r0 + 2 && cnt < 20) begin @(negedge clock); cnt++; end
    check("rsthi_reach", rd_cnt - r0, 2);
    #2 reset_n = 1'b0;
    #1;
    check("rsthi_req", mem_if.mem_request, 1'b0);
    check("rsthi_ready", load_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    hold_hi = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("rsthi_nodone", cnt, 0);
    check("rsthi_ready2", load_ready, 1'b1);
    check("rsthi_clr", {dwd, swd}, 80'h0);

    // Reset while a read request is stalled: request drops at once.
    mem_if.mem_ready = 1'b0;
    start_load("rstlo", 16'h0008);
    @(negedge clock);
    check("rstlo_req_on", mem_if.mem_request, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rstlo_req_off", mem_if.mem_request, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    mem_if.mem_ready = 1'b1;
    @(negedge clock);

    do_load("again", 16'h0008);
    check("again_lat", lat, 7);
    check("again_desc", c_dwd, 64'h00CF9B00_0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
